mem_ctrl: RTL

- Memory controller between the instruction cache, the load/store buffer, and the byte-wide unified RAM/IO port.
- Arbitrates the two requesters and serialises each 1/2/4-byte access into consecutive byte cycles.
- Returns one-cycle completion pulses carrying assembled 32-bit data.
- Stalls writes to the IO region while the IO output buffer is full.

---
 rtl/mem_ctrl_if.sv | 46 ++++
 rtl/mem_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: instruction-fetch port, load/store port and the
// byte-wide RAM/IO port. The slave modport is the controller's view; the
// master modport is the view of everything around it (requesters and RAM).
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  // instruction fetch port
  logic              is_ins_req;
  logic [ADDR_W-1:0] ins_addr;
  logic              is_ins_back;
  logic [31:0]       ins_data;

  // load/store port
  logic              is_ls_req;
  logic              ls_is_write;
  logic [1:0]        ls_len;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              is_ls_back;
  logic [31:0]       ls_rdata;

  // byte-wide RAM / IO port
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  is_ins_req, ins_addr,
    output is_ins_back, ins_data,
    input  is_ls_req, ls_is_write, ls_len, ls_addr, ls_wdata,
    output is_ls_back, ls_rdata,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output is_ins_req, ins_addr,
    input  is_ins_back, ins_data,
    output is_ls_req, ls_is_write, ls_len, ls_addr, ls_wdata,
    input  is_ls_back, ls_rdata,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates icache fetches against load/store accesses
// and serialises each 1/2/4-byte access onto a byte-wide RAM/IO port.
// RAM reads are registered, so a read byte is captured two edges after its
// address is driven. Writes into the IO region (addr[17:16] == 2'b11) are
// held off while the IO output buffer reports full.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter bit FAIR   = 1'b1
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // True when a byte address falls in the IO window.
  function automatic logic is_io_region(input logic [1:0] region);
    return (region == 2'b11);
  endfunction

  // Number of bytes moved for a load/store size code; 3 behaves as a word.
  function automatic logic [2:0] ls_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // transaction state
  state_e            state_q;
  logic [2:0]        cnt_q;       // READ: edges since grant; WRITE: bytes issued
  logic [2:0]        len_q;       // bytes in this transaction
  logic [ADDR_W-1:0] addr_q;
  logic              owner_ls_q;  // current transaction belongs to load/store
  logic              last_ls_q;   // last grant went to load/store
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;      // read bytes assembled so far

  // registered outputs
  logic              ins_back_q;
  logic [31:0]       ins_data_q;
  logic              ls_back_q;
  logic [31:0]       ls_rdata_q;
  logic [7:0]        mem_dout_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic              mem_wr_q;

  // combinational helpers
  logic              req_any_s;
  logic              grant_ls_s;
  logic              grant_wr_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic [2:0]        grant_len_s;
  logic [31:0]       grant_wdata_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [7:0]        wr_byte_s;
  logic [1:0]        cap_idx_s;
  logic [31:0]       cap_word_s;

  // Pick the requester to serve next and the parameters it would latch.
  always_comb begin
    req_any_s = bus.is_ins_req | bus.is_ls_req;
    if (bus.is_ins_req && bus.is_ls_req) begin
      if (FAIR) begin
        grant_ls_s = ~last_ls_q;
      end else begin
        grant_ls_s = 1'b1;
      end
    end else begin
      grant_ls_s = bus.is_ls_req;
    end

    if (grant_ls_s) begin
      grant_addr_s  = bus.ls_addr;
      grant_len_s   = ls_bytes(bus.ls_len);
      grant_wr_s    = bus.ls_is_write;
      grant_wdata_s = bus.ls_wdata;
    end else begin
      grant_addr_s  = bus.ins_addr;
      grant_len_s   = 3'd4;
      grant_wr_s    = 1'b0;
      grant_wdata_s = 32'd0;
    end
  end

  // Byte-lane datapath: next byte address, outgoing store byte, and the
  // read word with the byte currently on mem_din merged in.
  always_comb begin
    cur_addr_s = addr_q + ADDR_W'(cnt_q);

    case (cnt_q[1:0])
      2'd0:    wr_byte_s = wdata_q[7:0];
      2'd1:    wr_byte_s = wdata_q[15:8];
      2'd2:    wr_byte_s = wdata_q[23:16];
      default: wr_byte_s = wdata_q[31:24];
    endcase

    // byte j arrives on mem_din at edge j+2
    cap_idx_s  = cnt_q[1:0] - 2'd2;
    cap_word_s = rbuf_q;
    case (cap_idx_s)
      2'd0:    cap_word_s[7:0]   = bus.mem_din;
      2'd1:    cap_word_s[15:8]  = bus.mem_din;
      2'd2:    cap_word_s[23:16] = bus.mem_din;
      default: cap_word_s[31:24] = bus.mem_din;
    endcase
  end

  // Main controller FSM; every output is a register written here.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      addr_q     <= {ADDR_W{1'b0}};
      owner_ls_q <= 1'b0;
      last_ls_q  <= 1'b0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      ins_back_q <= 1'b0;
      ins_data_q <= 32'd0;
      ls_back_q  <= 1'b0;
      ls_rdata_q <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_a_q    <= {ADDR_W{1'b0}};
      mem_wr_q   <= 1'b0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          ins_back_q <= 1'b0;
          ls_back_q  <= 1'b0;
          mem_wr_q   <= 1'b0;
          if (req_any_s) begin
            owner_ls_q <= grant_ls_s;
            last_ls_q  <= grant_ls_s;
            addr_q     <= grant_addr_s;
            len_q      <= grant_len_s;
            wdata_q    <= grant_wdata_s;
            rbuf_q     <= 32'd0;
            mem_a_q    <= grant_addr_s;
            if (grant_wr_s) begin
              state_q <= WRITE;
              if (is_io_region(grant_addr_s[17:16]) && bus.io_buffer_full) begin
                cnt_q <= 3'd0;
              end else begin
                mem_dout_q <= grant_wdata_s[7:0];
                mem_wr_q   <= 1'b1;
                cnt_q      <= 3'd1;
              end
            end else begin
              state_q <= READ;
              cnt_q   <= 3'd1;
            end
          end
        end

        READ: begin
          if (cnt_q < len_q) begin
            mem_a_q <= cur_addr_s;
          end
          if (cnt_q >= 3'd2) begin
            rbuf_q <= cap_word_s;
          end
          if (cnt_q == (len_q + 3'd1)) begin
            state_q <= DONE;
            cnt_q   <= 3'd0;
            if (owner_ls_q) begin
              ls_back_q  <= 1'b1;
              ls_rdata_q <= cap_word_s;
            end else begin
              ins_back_q <= 1'b1;
              ins_data_q <= cap_word_s;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        WRITE: begin
          if (cnt_q == len_q) begin
            mem_wr_q  <= 1'b0;
            ls_back_q <= 1'b1;
            cnt_q     <= 3'd0;
            state_q   <= DONE;
          end else if (is_io_region(cur_addr_s[17:16]) && bus.io_buffer_full) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_a_q    <= cur_addr_s;
            mem_dout_q <= wr_byte_s;
            mem_wr_q   <= 1'b1;
            cnt_q      <= cnt_q + 3'd1;
          end
        end

        DONE: begin
          ins_back_q <= 1'b0;
          ls_back_q  <= 1'b0;
          mem_wr_q   <= 1'b0;
          state_q    <= IDLE;
        end

        default: begin
          ins_back_q <= 1'b0;
          ls_back_q  <= 1'b0;
          mem_wr_q   <= 1'b0;
          cnt_q      <= 3'd0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.is_ins_back = ins_back_q;
  assign bus.ins_data    = ins_data_q;
  assign bus.is_ls_back  = ls_back_q;
  assign bus.ls_rdata    = ls_rdata_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_wr      = mem_wr_q;

endmodule
